fpu_issuer: RTL and testbench

Initiator side of the floating-point unit interface. Accepts single-precision commands (A, B, opcode) over a valid/ready handshake, drives the FPU operand/opcode inputs, and waits a per-operation fixed latency. It then captures the FPU result and returns it over a second valid/ready handshake. One operation in flight; sits between the command source (sequencer/bus slave) and the FPU.

---
 rtl/fpu_issuer.sv | 131 +++++++++++++
 tb/tb_fpu_issuer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fpu_issuer: single-outstanding command issuer for a fixed-latency FPU.   |
// | Optional result classification enabled by FPU_ISSUE_STATUS_EN.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fpu_issuer #(
  parameter int ADD_LAT = 3,
  parameter int SUB_LAT = 3,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [1:0]  cmd_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [1:0]  fpu_opcode,
  input  logic [31:0] fpu_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [1:0]  res_op,
  output logic [2:0]  res_status,
  output logic        busy,
  output logic [15:0] op_count
);

  generate
    if (ADD_LAT < 1 || ADD_LAT > 255 || SUB_LAT < 1 || SUB_LAT > 255 ||
        MUL_LAT < 1 || MUL_LAT > 255 || DIV_LAT < 1 || DIV_LAT > 255) begin : g_lat_range_error
      $error("fpu_issuer: every *_LAT parameter must lie in 1..255");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] cnt;

  // Counter is preloaded with LAT-1 so the capture lands exactly LAT edges after launch.
  function automatic logic [7:0] lat_m1(input logic [1:0] op);
    case (op)
      2'b00:   return 8'(ADD_LAT - 1);
      2'b01:   return 8'(SUB_LAT - 1);
      2'b10:   return 8'(MUL_LAT - 1);
      default: return 8'(DIV_LAT - 1);
    endcase
  endfunction

`ifdef FPU_ISSUE_STATUS_EN
  function automatic logic [2:0] classify(input logic [31:0] d);
    logic exp_ones;
    logic exp_zero;
    logic mant_zero;
    exp_ones  = (d[30:23] == 8'hFF);
    exp_zero  = (d[30:23] == 8'h00);
    mant_zero = (d[22:0] == 23'd0);
    return {exp_ones && !mant_zero, exp_ones && mant_zero, exp_zero && mant_zero};
  endfunction
`else
  assign res_status = 3'b000;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      cmd_ready  <= 1'b0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
      fpu_a      <= 32'd0;
      fpu_b      <= 32'd0;
      fpu_opcode <= 2'b00;
      res_data   <= 32'd0;
      res_op     <= 2'b00;
      op_count   <= 16'd0;
`ifdef FPU_ISSUE_STATUS_EN
      res_status <= 3'b000;
`endif
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            fpu_a      <= cmd_a;
            fpu_b      <= cmd_b;
            fpu_opcode <= cmd_op;
            res_op     <= cmd_op;
            cnt        <= lat_m1(cmd_op);
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            res_data  <= fpu_result;
`ifdef FPU_ISSUE_STATUS_EN
            res_status <= classify(fpu_result);
`endif
            res_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            op_count  <= op_count + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fpu_issuer: scoreboard bench for fpu_issuer with a timed FPU model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fpu_issuer;

  localparam int ADD_L = 3;
  localparam int SUB_L = 1;
  localparam int MUL_L = 5;
  localparam int DIV_L = 8;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [1:0]  cmd_op;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [1:0]  fpu_opcode;
  logic [31:0] fpu_result;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [1:0]  res_op;
  logic [2:0]  res_status;
  logic        busy;
  logic [15:0] op_count;

  fpu_issuer #(
    .ADD_LAT(ADD_L), .SUB_LAT(SUB_L), .MUL_LAT(MUL_L), .DIV_LAT(DIV_L)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode),
    .fpu_result(fpu_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op), .res_status(res_status),
    .busy(busy), .op_count(op_count)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  op;
    logic [2:0]  status;
    int          cap;
  } exp_t;

  exp_t        q[$];
  int          edge_cnt = 0;
  bit          armed = 0;
  logic [15:0] exp_count = 16'd0;
  logic [31:0] exp_fa = 32'd0;
  logic [31:0] exp_fb = 32'd0;
  logic [1:0]  exp_fop = 2'd0;
  logic [31:0] cmd_exp = 32'd0;
  int          rr_mode = 0;
  bit          done = 0;
  bit          preload_req = 0;
  int          drv_timeouts = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic int lat_of(input logic [1:0] op);
    case (op)
      2'b00:   return ADD_L;
      2'b01:   return SUB_L;
      2'b10:   return MUL_L;
      default: return DIV_L;
    endcase
  endfunction

  function automatic logic [2:0] status_of(input logic [31:0] d);
`ifdef FPU_ISSUE_STATUS_EN
    int e;
    int m;
    e = int'(d[30:23]);
    m = int'(d[22:0]);
    return {(e == 255) && (m != 0), (e == 255) && (m == 0), (e == 0) && (m == 0)};
`else
    return 3'b000 & d[2:0];
`endif
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: handshakes, latency bookkeeping and the FPU's timed result.
  initial begin
    bit ready_pre;
    exp_t e;
    fpu_result = 32'd0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        q.delete();
        armed     = 0;
        exp_count = 16'd0;
        exp_fa    = 32'd0;
        exp_fb    = 32'd0;
        exp_fop   = 2'd0;
        edge_cnt++;
        fpu_result <= $urandom;
      end else begin
        ready_pre = armed && (q.size() == 0);
        if (q.size() > 0 && edge_cnt >= q[0].cap && res_ready) begin
          void'(q.pop_front());
          exp_count = exp_count + 16'd1;
        end
        if (preload_req) exp_count = 16'hFFFF;
        edge_cnt++;
        if (cmd_valid && ready_pre) begin
          e.data   = cmd_exp;
          e.op     = cmd_op;
          e.status = status_of(cmd_exp);
          e.cap    = edge_cnt + lat_of(cmd_op);
          q.push_back(e);
          exp_fa  = cmd_a;
          exp_fb  = cmd_b;
          exp_fop = cmd_op;
        end
        armed = 1;
        if (q.size() > 0 && q[0].cap == edge_cnt + 1)
          fpu_result <= q[0].data;
        else if (q.size() > 0)
          fpu_result <= q[0].data ^ 32'h5A5A_0001;
        else
          fpu_result <= $urandom;
      end
    end
  end

  initial begin
    res_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rr_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'($urandom_range(0, 1));
        default: res_ready = 1'b0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, expv, edge_cnt);
    end
  endtask

  // Monitor: compares every visible output against the model once per cycle.
  initial begin
    bit ev;
    forever begin
      @(negedge clk);
      #1;
      if (done || edge_cnt > 20000) begin
        chk("watchdog", 32'(done), 32'd1);
        chk("driver_timeouts", drv_timeouts, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
      if (!rst_n) begin
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fpu_a", fpu_a, 32'd0);
        chk("rst_fpu_b", fpu_b, 32'd0);
        chk("rst_fpu_opcode", 32'(fpu_opcode), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_op", 32'(res_op), 32'd0);
        chk("rst_res_status", 32'(res_status), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
      end else begin
        ev = (q.size() > 0) && (edge_cnt >= q[0].cap);
        chk("cmd_ready", 32'(cmd_ready), 32'(armed && q.size() == 0));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        chk("res_valid", 32'(res_valid), 32'(ev));
        chk("fpu_a", fpu_a, exp_fa);
        chk("fpu_b", fpu_b, exp_fb);
        chk("fpu_opcode", 32'(fpu_opcode), 32'(exp_fop));
        if (!preload_req) chk("op_count", 32'(op_count), 32'(exp_count));
        if (ev) begin
          chk("res_data", res_data, q[0].data);
          chk("res_op", 32'(res_op), 32'(q[0].op));
          chk("res_status", 32'(res_status), 32'(q[0].status));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [31:0] r, input bit hold);
    bit got;
    got       = 0;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_exp   = r;
    cmd_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (cmd_ready === 1'b1) begin
        got = 1;
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!got) drv_timeouts++;
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int n = 0; n < 500; n++) begin
      if (q.size() == 0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) drv_timeouts++;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rr;
    logic [1:0]  rop;
    logic        s;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = 32'd0;
    cmd_b     = 32'd0;
    cmd_op    = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'h3FC00000, 32'h40100000, 2'b00, 32'h40700000, 0);
    wait_idle();
    issue(32'h3F800000, 32'h00000000, 2'b11, 32'h7F800000, 0);
    wait_idle();

    rr_mode = 2;
    issue(32'h40000000, 32'h40400000, 2'b10, 32'h40C00000, 0);
    repeat (5) @(negedge clk);
    cmd_a     = 32'h12345678;
    cmd_b     = 32'h9ABCDEF0;
    cmd_op    = 2'b01;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    rr_mode = 0;
    wait_idle();

    issue(32'h11111111, 32'h22222222, 2'b01, 32'h80000000, 1);
    issue(32'h33333333, 32'h44444444, 2'b00, 32'h7FC00001, 0);
    wait_idle();

    issue(32'h40A00000, 32'h40000000, 2'b11, 32'h40200000, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(32'h3F800000, 32'h3F800000, 2'b00, 32'h40000000, 0);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      s   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       rr = {s, 31'd0};
        1:       rr = {s, 8'hFF, 23'd0};
        2:       rr = {s, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
        3:       rr = {s, 8'h00, 23'($urandom_range(1, 32'h7FFFFF))};
        default: rr = $urandom;
      endcase
      rr_mode = $urandom_range(0, 1);
      issue(ra, rb, rop, rr, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    cmd_valid = 1'b0;
    rr_mode   = 0;
    wait_idle();

    @(posedge clk);
    #1;
    force dut.op_count = 16'hFFFF;
    preload_req = 1;
    @(posedge clk);
    #1;
    release dut.op_count;
    preload_req = 0;
    @(negedge clk);
    issue(32'h40400000, 32'h3F800000, 2'b01, 32'h40000000, 0);
    wait_idle();
    repeat (2) @(negedge clk);
    done = 1;
  end

endmodule
`default_nettype wire
